// File: rtl/pipe_reg_file_if.sv
// rtl/pipe_reg_file_if.sv - read/writeback/issue bundle for the pipelined register file
interface pipe_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rw;
    logic [ADDR_W-1:0] da;
    logic [DATA_W-1:0] bus_d;
    logic [ADDR_W-1:0] aa;
    logic [ADDR_W-1:0] ba;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic              busy_a;
    logic              busy_b;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output rw, da, bus_d, aa, ba, iss_valid, iss_addr,
        input  reg_a, reg_b, busy_a, busy_b, pend_cnt
    );

    modport slave (
        input  rw, da, bus_d, aa, ba, iss_valid, iss_addr,
        output reg_a, reg_b, busy_a, busy_b, pend_cnt
    );
endinterface

// File: rtl/pipe_reg_file.sv
// rtl/pipe_reg_file.sv - 2R/1W register file with pending-write scoreboard
// Optional same-cycle writeback bypass enabled by `define RF_BYPASS_EN.
module pipe_reg_file #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_reg_file_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = ADDR_W + 1;
    localparam bit Z0    = (ZERO_R0 != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CW-1:0]     pend_cnt_q, pend_cnt_d;
    logic              wr_ok, iss_ok, cnt_inc, cnt_dec;

    // Accesses to R0 are dropped up front so the rest of the logic never special-cases it.
    assign wr_ok  = rf.rw        && !(Z0 && (rf.da == '0));
    assign iss_ok = rf.iss_valid && !(Z0 && (rf.iss_addr == '0));

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (iss_ok && (rf.iss_addr == ADDR_W'(r)))
                busy_d[r] = 1'b1;
            else if (wr_ok && (rf.da == ADDR_W'(r)))
                busy_d[r] = 1'b0;
        end
    end

    // Same-address issue+writeback keeps the bit set, so it can never count as a clear.
    assign cnt_inc = iss_ok && !busy_q[rf.iss_addr];
    assign cnt_dec = wr_ok && busy_q[rf.da] && !(iss_ok && (rf.iss_addr == rf.da));

    always_comb begin
        pend_cnt_d = pend_cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++)
                mem_q[r] <= '0;
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            if (wr_ok)
                mem_q[rf.da] <= rf.bus_d;
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign rf.pend_cnt = pend_cnt_q;

`ifdef RF_BYPASS_EN
    always_comb begin
        rf.reg_a  = mem_q[rf.aa];
        rf.reg_b  = mem_q[rf.ba];
        rf.busy_a = busy_q[rf.aa];
        rf.busy_b = busy_q[rf.ba];
        if (wr_ok && (rf.da == rf.aa)) begin
            rf.reg_a  = rf.bus_d;
            rf.busy_a = iss_ok && (rf.iss_addr == rf.aa);
        end
        if (wr_ok && (rf.da == rf.ba)) begin
            rf.reg_b  = rf.bus_d;
            rf.busy_b = iss_ok && (rf.iss_addr == rf.ba);
        end
    end
`else
    always_comb begin
        rf.reg_a  = mem_q[rf.aa];
        rf.reg_b  = mem_q[rf.ba];
        rf.busy_a = busy_q[rf.aa];
        rf.busy_b = busy_q[rf.ba];
    end
`endif
endmodule

// File: tb/tb_pipe_reg_file.sv
// tb/tb_pipe_reg_file.sv - randomized self-checking bench for pipe_reg_file
module tb_pipe_reg_file;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_reg_file_if #(.DATA_W(32), .ADDR_W(5)) rf_if ();

    pipe_reg_file #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_if)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem  [32];
    bit          ref_busy [32];

    logic [31:0] obs_a, obs_b;
    logic        obs_ba, obs_bb;
    logic [5:0]  obs_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int ref_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += ref_busy[i];
        return n;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic w,
                                              input logic [4:0] d, input logic [31:0] data);
        logic [31:0] v;
        v = (a == 0) ? 32'h0 : ref_mem[a];
`ifdef RF_BYPASS_EN
        if (w && d == a && d != 0) v = data;
`endif
        return v;
    endfunction

    function automatic logic ref_busy_rd(input logic [4:0] a, input logic w, input logic [4:0] d,
                                         input logic iv, input logic [4:0] ia);
        logic b;
        b = ref_busy[a];
`ifdef RF_BYPASS_EN
        if (w && d == a && d != 0 && !(iv && ia == a)) b = 1'b0;
`endif
        return b;
    endfunction

    // Drive one cycle, check all outputs mid-cycle against the model, then advance the model.
    task automatic do_cycle(input logic r_n, input logic w, input logic [4:0] d,
                            input logic [31:0] data, input logic [4:0] a, input logic [4:0] b,
                            input logic iv, input logic [4:0] ia);
        @(negedge clk);
        rst_n = r_n;
        rf_if.rw = w; rf_if.da = d; rf_if.bus_d = data;
        rf_if.aa = a; rf_if.ba = b;
        rf_if.iss_valid = iv; rf_if.iss_addr = ia;
        #1;
        obs_a = rf_if.reg_a; obs_b = rf_if.reg_b;
        obs_ba = rf_if.busy_a; obs_bb = rf_if.busy_b;
        obs_cnt = rf_if.pend_cnt;
        chk("reg_a",    obs_a, ref_read(a, w, d, data));
        chk("reg_b",    obs_b, ref_read(b, w, d, data));
        chk("busy_a",   {31'b0, obs_ba}, {31'b0, ref_busy_rd(a, w, d, iv, ia)});
        chk("busy_b",   {31'b0, obs_bb}, {31'b0, ref_busy_rd(b, w, d, iv, ia)});
        chk("pend_cnt", {26'b0, obs_cnt}, 32'(ref_count()));
        @(posedge clk);
        if (!r_n) begin
            for (int i = 0; i < 32; i++) begin
                ref_mem[i] = '0;
                ref_busy[i] = 1'b0;
            end
        end else begin
            if (w && d != 0) begin
                ref_mem[d] = data;
                ref_busy[d] = 1'b0;
            end
            if (iv && ia != 0) ref_busy[ia] = 1'b1;
        end
    endtask

    task automatic idle(input logic [4:0] a, input logic [4:0] b);
        do_cycle(1'b1, 1'b0, 5'd0, 32'h0, a, b, 1'b0, 5'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = 'x;
            ref_busy[i] = 1'b0;
        end
        rst_n = 1'b0;
        rf_if.rw = 0; rf_if.da = 0; rf_if.bus_d = 0; rf_if.aa = 0; rf_if.ba = 0;
        rf_if.iss_valid = 0; rf_if.iss_addr = 0;
        // Initial reset: model state is unknown until the reset edge, so skip checks there.
        @(posedge clk);
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;

        // 1: random writes then reset, then every register reads 0
        for (int i = 0; i < 8; i++)
            do_cycle(1, 1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom), 5'($urandom),
                     1, 5'($urandom));
        do_cycle(0, 1, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd4, 1, 5'd3);
        for (int i = 0; i < 32; i += 2) idle(5'(i), 5'(i + 1));
        chk("rst_cnt", {26'b0, obs_cnt}, 32'd0);

        // 2: R5 write/readback, R0 write dropped
        do_cycle(1, 1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 0, 5'd0);
        idle(5'd5, 5'd5);
        chk("r5_a", obs_a, 32'hDEAD_BEEF);
        chk("r5_b", obs_b, 32'hDEAD_BEEF);
        do_cycle(1, 1, 5'd0, 32'h1234, 5'd1, 5'd1, 0, 5'd0);
        idle(5'd0, 5'd0);
        chk("r0_zero", obs_a, 32'h0);

        // 3: issue/writeback R7
        do_cycle(1, 0, 5'd0, 0, 5'd7, 5'd7, 1, 5'd7);
        idle(5'd7, 5'd0);
        chk("r7_busy", {31'b0, obs_ba}, 32'd1);
        chk("r7_cnt", {26'b0, obs_cnt}, 32'd1);
        do_cycle(1, 1, 5'd7, 32'h55, 5'd0, 5'd0, 0, 5'd0);
        idle(5'd7, 5'd7);
        chk("r7_clr", {31'b0, obs_ba}, 32'd0);
        chk("r7_cnt0", {26'b0, obs_cnt}, 32'd0);
        chk("r7_data", obs_a, 32'h55);

        // 4: same-edge issue+writeback R9, then issue R3 with writeback of busy R4
        do_cycle(1, 1, 5'd9, 32'h99, 5'd9, 5'd9, 1, 5'd9);
        do_cycle(1, 0, 5'd0, 0, 5'd4, 5'd4, 1, 5'd4);
        idle(5'd9, 5'd4);
        chk("r9_busy", {31'b0, obs_ba}, 32'd1);
        chk("cnt2", {26'b0, obs_cnt}, 32'd2);
        do_cycle(1, 1, 5'd4, 32'h44, 5'd3, 5'd4, 1, 5'd3);
        idle(5'd3, 5'd4);
        chk("cnt_net0", {26'b0, obs_cnt}, 32'd2);

        // 5: same-cycle write and read of R12
        do_cycle(1, 1, 5'd12, 32'h1111_1111, 5'd0, 5'd0, 0, 5'd0);
        do_cycle(1, 1, 5'd12, 32'hA5A5_A5A5, 5'd12, 5'd12, 0, 5'd0);
`ifdef RF_BYPASS_EN
        chk("byp_a", obs_a, 32'hA5A5_A5A5);
`else
        chk("byp_a", obs_a, 32'h1111_1111);
`endif

        // 6: fill scoreboard, then reset mid-sequence
        do_cycle(0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 5'd0);
        for (int i = 1; i < 32; i++) idle_issue: do_cycle(1, 0, 5'd0, 0, 5'(i), 5'd31, 1, 5'(i));
        idle(5'd1, 5'd31);
        chk("cnt31", {26'b0, obs_cnt}, 32'd31);
        for (int i = 1; i < 16; i++) do_cycle(1, 1, 5'(i), 32'(i), 5'(i), 5'd0, 0, 5'd0);
        for (int i = 1; i < 12; i++) do_cycle(1, 0, 5'd0, 0, 5'(i), 5'd20, 1, 5'(i));
        do_cycle(0, 0, 5'd0, 0, 5'd0, 5'd0, 1, 5'd13);
        idle(5'd20, 5'd5);
        chk("cnt_rst", {26'b0, obs_cnt}, 32'd0);

        // Random traffic, narrow address range to make collisions frequent
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] hi;
            hi = (n < 1500) ? 5'd7 : 5'd31;
            do_cycle(($urandom_range(0, 99) != 0),
                     $urandom_range(0, 1) == 1, 5'($urandom_range(0, hi)), $urandom,
                     5'($urandom_range(0, hi)), 5'($urandom_range(0, hi)),
                     $urandom_range(0, 1) == 1, 5'($urandom_range(0, hi)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
